// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags at issue, captures CDB results, retires in program order.
// Latency: tag granted combinationally at issue; CDB write at edge N commits no earlier than cycle N+1.
// Backpressure: issue_ready_o low when full or recovering; commit_stall_i holds the head. Option: ROB_OPERAND_READ_EN.
module reorder_buffer #(
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             issue_valid_i,
   output logic             issue_ready_o,
   input  logic [4:0]       issue_dst_i,
   input  logic             issue_store_i,
   input  logic             issue_branch_i,
   output logic [TAG_W-1:0] issue_rob_tag_o,
   input  logic             cdb_valid_i,
   input  logic [TAG_W-1:0] cdb_rob_tag_i,
   input  logic [XLEN-1:0]  cdb_value_i,
   input  logic             cdb_mispredict_i,
   input  logic [XLEN-1:0]  cdb_target_i,
   input  logic             commit_stall_i,
   output logic             commit_valid_o,
   output logic [TAG_W-1:0] commit_rob_tag_o,
   output logic [4:0]       commit_dst_o,
   output logic [XLEN-1:0]  commit_value_o,
   output logic             commit_store_o,
   output logic             recover_en_o,
   output logic [XLEN-1:0]  recover_pc_o,
`ifdef ROB_OPERAND_READ_EN
   input  logic [TAG_W-1:0] rd_tag1_i,
   input  logic [TAG_W-1:0] rd_tag2_i,
   output logic             rd_ready1_o,
   output logic             rd_ready2_o,
   output logic [XLEN-1:0]  rd_value1_o,
   output logic [XLEN-1:0]  rd_value2_o,
`endif
   output logic [TAG_W:0]   count_o
);

   localparam int DEPTH = 2**TAG_W;

   typedef struct packed {
      logic            valid;
      logic            done;
      logic [4:0]      dst;
      logic            store;
      logic            branch;
      logic            mispredict;
      logic [XLEN-1:0] value;
      logic [XLEN-1:0] target;
   } entry_t;

   entry_t           rob_q [DEPTH];
   logic [TAG_W-1:0] head_q;
   logic [TAG_W-1:0] tail_q;
   logic [TAG_W:0]   count_q;

   entry_t           head_e;
   logic             issue_fire;
   logic             cdb_hit;

   // The head entry drives every commit/recovery output; no CDB bypass, so only stored state is used.
   always_comb begin
      head_e         = rob_q[head_q];
      commit_valid_o = head_e.valid && head_e.done && !commit_stall_i;
      recover_en_o   = commit_valid_o && head_e.mispredict;
      issue_ready_o  = (count_q < (TAG_W+1)'(DEPTH)) && !recover_en_o;
      issue_fire     = issue_valid_i && issue_ready_o;
      cdb_hit        = cdb_valid_i && rob_q[cdb_rob_tag_i].valid;
   end

   assign issue_rob_tag_o  = tail_q;
   assign commit_rob_tag_o = head_q;
   assign commit_dst_o     = head_e.dst;
   assign commit_value_o   = head_e.value;
   assign commit_store_o   = head_e.store;
   assign recover_pc_o     = head_e.target;
   assign count_o          = count_q;

`ifdef ROB_OPERAND_READ_EN
   // Operand bypass reads for issue: completed-but-uncommitted results.
   always_comb begin
      rd_ready1_o = rob_q[rd_tag1_i].valid && rob_q[rd_tag1_i].done;
      rd_ready2_o = rob_q[rd_tag2_i].valid && rob_q[rd_tag2_i].done;
      rd_value1_o = rob_q[rd_tag1_i].value;
      rd_value2_o = rob_q[rd_tag2_i].value;
   end
`endif

   // Entry storage and pointers: recovery flushes everything, otherwise issue/CDB/commit all apply in one edge.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            rob_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (recover_en_o) begin
         // The mispredicted branch retires this cycle; everything younger is discarded with it.
         for (int i = 0; i < DEPTH; i++) begin
            rob_q[i].valid <= 1'b0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (issue_fire) begin
            rob_q[tail_q].valid      <= 1'b1;
            rob_q[tail_q].done       <= 1'b0;
            rob_q[tail_q].dst        <= issue_dst_i;
            rob_q[tail_q].store      <= issue_store_i;
            rob_q[tail_q].branch     <= issue_branch_i;
            rob_q[tail_q].mispredict <= 1'b0;
            tail_q                   <= tail_q + 1'b1;
         end
         // The tail entry is never valid, so a CDB hit can't collide with the issue write.
         if (cdb_hit) begin
            rob_q[cdb_rob_tag_i].done  <= 1'b1;
            rob_q[cdb_rob_tag_i].value <= cdb_value_i;
            if (rob_q[cdb_rob_tag_i].branch) begin
               rob_q[cdb_rob_tag_i].mispredict <= cdb_mispredict_i;
               rob_q[cdb_rob_tag_i].target     <= cdb_target_i;
            end
         end
         if (commit_valid_o) begin
            rob_q[head_q].valid <= 1'b0;
            head_q              <= head_q + 1'b1;
         end
         case ({issue_fire, commit_valid_o})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: scoreboard of expected commits, popped at each observed retirement.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Covers in-order retirement, full/wrap, mispredict recovery, commit stall, async reset, operand reads.
`timescale 1ns/1ps
module tb_reorder_buffer;
   localparam int TAG_W = 4;
   localparam int XLEN  = 32;
   localparam int DEPTH = 16;

   logic             clk_i = 1'b0;
   logic             reset_ni;
   logic             issue_valid_i;
   logic             issue_ready_o;
   logic [4:0]       issue_dst_i;
   logic             issue_store_i;
   logic             issue_branch_i;
   logic [TAG_W-1:0] issue_rob_tag_o;
   logic             cdb_valid_i;
   logic [TAG_W-1:0] cdb_rob_tag_i;
   logic [XLEN-1:0]  cdb_value_i;
   logic             cdb_mispredict_i;
   logic [XLEN-1:0]  cdb_target_i;
   logic             commit_stall_i;
   logic             commit_valid_o;
   logic [TAG_W-1:0] commit_rob_tag_o;
   logic [4:0]       commit_dst_o;
   logic [XLEN-1:0]  commit_value_o;
   logic             commit_store_o;
   logic             recover_en_o;
   logic [XLEN-1:0]  recover_pc_o;
   logic [TAG_W:0]   count_o;
`ifdef ROB_OPERAND_READ_EN
   logic [TAG_W-1:0] rd_tag1_i;
   logic [TAG_W-1:0] rd_tag2_i;
   logic             rd_ready1_o;
   logic             rd_ready2_o;
   logic [XLEN-1:0]  rd_value1_o;
   logic [XLEN-1:0]  rd_value2_o;
`endif

   always #5 clk_i = ~clk_i;

   reorder_buffer #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_dst_i(issue_dst_i), .issue_store_i(issue_store_i),
      .issue_branch_i(issue_branch_i), .issue_rob_tag_o(issue_rob_tag_o),
      .cdb_valid_i(cdb_valid_i), .cdb_rob_tag_i(cdb_rob_tag_i),
      .cdb_value_i(cdb_value_i), .cdb_mispredict_i(cdb_mispredict_i),
      .cdb_target_i(cdb_target_i), .commit_stall_i(commit_stall_i),
      .commit_valid_o(commit_valid_o), .commit_rob_tag_o(commit_rob_tag_o),
      .commit_dst_o(commit_dst_o), .commit_value_o(commit_value_o),
      .commit_store_o(commit_store_o), .recover_en_o(recover_en_o),
      .recover_pc_o(recover_pc_o),
`ifdef ROB_OPERAND_READ_EN
      .rd_tag1_i(rd_tag1_i), .rd_tag2_i(rd_tag2_i),
      .rd_ready1_o(rd_ready1_o), .rd_ready2_o(rd_ready2_o),
      .rd_value1_o(rd_value1_o), .rd_value2_o(rd_value2_o),
`endif
      .count_o(count_o)
   );

   int n_checks = 0;
   int n_fails  = 0;
   int exp_tail = 0;
   int recover_cnt = 0;

   typedef struct {
      int         tag;
      logic [4:0] dst;
      logic       store;
   } exp_t;
   exp_t sbq[$];

   logic [XLEN-1:0] m_val    [DEPTH];
   logic            m_branch [DEPTH];
   logic            m_misp   [DEPTH];
   logic [XLEN-1:0] m_tgt    [DEPTH];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Commit monitor: every retirement must match the oldest outstanding scoreboard entry.
   always @(negedge clk_i) begin
      if (reset_ni && commit_valid_o) begin
         if (sbq.size() == 0) begin
            check_eq("commit_when_empty", commit_valid_o, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check_eq("commit_tag", commit_rob_tag_o, e.tag);
            check_eq("commit_dst", commit_dst_o, e.dst);
            check_eq("commit_store", commit_store_o, e.store);
            check_eq("commit_value", commit_value_o, m_val[e.tag]);
            check_eq("commit_recover", recover_en_o, m_branch[e.tag] && m_misp[e.tag]);
            if (m_branch[e.tag] && m_misp[e.tag]) begin
               check_eq("recover_pc", recover_pc_o, m_tgt[e.tag]);
               recover_cnt++;
               sbq.delete();
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      issue_valid_i = 0; issue_dst_i = '0; issue_store_i = 0; issue_branch_i = 0;
      cdb_valid_i = 0; cdb_rob_tag_i = '0; cdb_value_i = '0; cdb_mispredict_i = 0;
      cdb_target_i = '0; commit_stall_i = 0;
`ifdef ROB_OPERAND_READ_EN
      rd_tag1_i = '0; rd_tag2_i = '0;
`endif
   endtask

   task automatic do_reset();
      reset_ni = 0;
      clear_inputs();
      sbq.delete();
      exp_tail = 0;
      #2;
      reset_ni = 1;
      step();
   endtask

   task automatic issue(input logic [4:0] dst, input logic st, input logic br);
      issue_valid_i = 1; issue_dst_i = dst; issue_store_i = st; issue_branch_i = br;
      @(negedge clk_i);
      check_eq("issue_ready", issue_ready_o, 1);
      check_eq("issue_tag", issue_rob_tag_o, exp_tail);
      sbq.push_back('{exp_tail, dst, st});
      m_branch[exp_tail] = br; m_misp[exp_tail] = 0; m_val[exp_tail] = '0;
      exp_tail = (exp_tail + 1) % DEPTH;
      step();
      issue_valid_i = 0;
   endtask

   task automatic cdb(input int tag, input logic [XLEN-1:0] v, input logic mis, input logic [XLEN-1:0] tgt);
      cdb_valid_i = 1; cdb_rob_tag_i = TAG_W'(tag); cdb_value_i = v;
      cdb_mispredict_i = mis; cdb_target_i = tgt;
      m_val[tag] = v;
      if (m_branch[tag]) begin
         m_misp[tag] = mis;
         m_tgt[tag]  = tgt;
      end
      step();
      cdb_valid_i = 0; cdb_mispredict_i = 0;
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (count_o != 0 && n < 60) begin
         step();
         n++;
      end
      check_eq(tag, count_o, 0);
      check_eq({tag, "_sb"}, sbq.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      reset_ni = 0;
      clear_inputs();
      #3;
      check_eq("rst_count", count_o, 0);
      check_eq("rst_issue_ready", issue_ready_o, 1);
      check_eq("rst_issue_tag", issue_rob_tag_o, 0);
      check_eq("rst_commit_valid", commit_valid_o, 0);
      check_eq("rst_recover_en", recover_en_o, 0);
      check_eq("rst_commit_dst", commit_dst_o, 0);
      check_eq("rst_commit_value", commit_value_o, 0);
      check_eq("rst_recover_pc", recover_pc_o, 0);
      step();
      reset_ni = 1;

      // In-order retirement of out-of-order completions
      issue(5'd5, 0, 0);
      issue(5'd6, 0, 0);
      issue(5'd7, 0, 0);
      @(negedge clk_i);
      check_eq("count_three", count_o, 3);
      step();
      cdb(2, 32'h2222_0002, 0, '0);
      @(negedge clk_i);
      check_eq("no_commit_head_not_done", commit_valid_o, 0);
      step();
      cdb_valid_i = 1; cdb_rob_tag_i = '0; cdb_value_i = 32'h1000_000A; m_val[0] = 32'h1000_000A;
      @(negedge clk_i);
      check_eq("no_cdb_bypass", commit_valid_o, 0);
      step();
      cdb_valid_i = 0;
      cdb(1, 32'h1111_0001, 0, '0);
      wait_empty("drain_t1");

      // Full buffer, commit while full, wrap-around of the tail
      do_reset();
      for (int i = 0; i < DEPTH; i++) issue(5'(i + 8), i[0], 0);
      @(negedge clk_i);
      check_eq("full_count", count_o, 16);
      check_eq("full_ready", issue_ready_o, 0);
      step();
      cdb(0, 32'hA000_0000, 0, '0);
      issue_valid_i = 1; issue_dst_i = 5'd20; issue_store_i = 0; issue_branch_i = 0;
      @(negedge clk_i);
      check_eq("full_ready_during_commit", issue_ready_o, 0);
      check_eq("full_commit_valid", commit_valid_o, 1);
      step();
      issue(5'd20, 0, 0);
      @(negedge clk_i);
      check_eq("refill_count", count_o, 16);
      step();
      for (int t = 1; t < DEPTH; t++) cdb(t, 32'hA000_0000 + t, 0, '0);
      cdb(0, 32'hB000_0000, 0, '0);
      wait_empty("drain_t2");

      // Mispredict recovery at tag 3
      do_reset();
      for (int i = 0; i < 7; i++) issue(5'(i + 1), 0, i == 3);
      cdb(4, 32'h4444_0004, 0, '0);
      cdb(5, 32'h5555_0005, 0, '0);
      cdb(6, 32'h6666_0006, 0, '0);
      cdb(3, 32'h3333_0003, 1, 32'h0000_0100);
      cdb(0, 32'h0000_1000, 0, '0);
      cdb(1, 32'h0000_1001, 1, 32'h0000_0BAD);
      cdb(2, 32'h0000_1002, 0, '0);
      step();
      issue_valid_i = 1; issue_dst_i = 5'd9;
      cdb_valid_i = 1; cdb_rob_tag_i = 4'd0; cdb_value_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      check_eq("rec_en", recover_en_o, 1);
      check_eq("rec_pc", recover_pc_o, 32'h100);
      check_eq("rec_tag", commit_rob_tag_o, 3);
      check_eq("rec_issue_ready", issue_ready_o, 0);
      step();
      clear_inputs();
      exp_tail = 0;
      @(negedge clk_i);
      check_eq("post_rec_en", recover_en_o, 0);
      check_eq("post_rec_count", count_o, 0);
      check_eq("post_rec_tag", issue_rob_tag_o, 0);
      check_eq("post_rec_ready", issue_ready_o, 1);
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check_eq("flushed_no_commit", commit_valid_o, 0);
         step();
      end
      check_eq("rec_pulse_count", recover_cnt, 1);

      // Commit stall holds the head, x0 destination retires normally
      do_reset();
      issue(5'd12, 1, 0);
      issue(5'd0, 0, 0);
      cdb(0, 32'h5555_AAAA, 0, '0);
      commit_stall_i = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check_eq("stall_commit_valid", commit_valid_o, 0);
         check_eq("stall_tag", commit_rob_tag_o, 0);
         check_eq("stall_dst", commit_dst_o, 12);
         check_eq("stall_value", commit_value_o, 32'h5555_AAAA);
         step();
      end
      commit_stall_i = 0;
      @(negedge clk_i);
      check_eq("unstall_commit", commit_valid_o, 1);
      step();
      cdb(1, 32'h0BAD_F00D, 0, '0);
      wait_empty("drain_stall");

      // Asynchronous reset with entries in flight
      for (int i = 0; i < 5; i++) issue(5'(i + 2), 0, 0);
      cdb(exp_tail - 5 < 0 ? exp_tail + 11 : exp_tail - 5, 32'h7777_0000, 0, '0);
      #2;
      reset_ni = 0;
      sbq.delete();
      exp_tail = 0;
      #1;
      check_eq("arst_count", count_o, 0);
      check_eq("arst_ready", issue_ready_o, 1);
      check_eq("arst_tag", issue_rob_tag_o, 0);
      check_eq("arst_commit_valid", commit_valid_o, 0);
      check_eq("arst_recover", recover_en_o, 0);
      check_eq("arst_commit_value", commit_value_o, 0);
      reset_ni = 1;
      step();

`ifdef ROB_OPERAND_READ_EN
      for (int i = 0; i < 5; i++) issue(5'(i + 1), 0, 0);
      cdb(4, 32'hDEAD_BEEF, 0, '0);
      rd_tag1_i = 4'd4; rd_tag2_i = 4'd2;
      @(negedge clk_i);
      check_eq("rd_ready1", rd_ready1_o, 1);
      check_eq("rd_value1", rd_value1_o, 32'hDEAD_BEEF);
      check_eq("rd_ready2", rd_ready2_o, 0);
      step();
`else
      issue(5'd3, 0, 0);
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
